exe_stage: RTL

- Execute stage of the five-stage pipeline. It is the consumer end of the 171-bit ID->EXE bus that the decode stage drives.
- It holds the ID/EXE pipeline register, runs the one-hot ALU, checks signed overflow, owns the HI/LO registers, and performs MULT with an iterative multi-cycle multiplier.
- It drives the EXE->MEM bus, the EXE_wdest hazard feedback to decode, and the allow-in/over handshakes.

---
 rtl/exe_stage.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/exe_stage.sv
// rtl/exe_stage.sv - execute stage: ID/EXE register, one-hot ALU, overflow check, HI/LO and iterative MULT
module exe_stage #(
    parameter int MUL_CYCLES = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         ID_over,
    input  logic [170:0] ID_EXE_bus,
    input  logic         MEM_allow_in,
    input  logic         cancel,
    output logic         EXE_allow_in,
    output logic         EXE_valid,
    output logic         EXE_over,
    output logic [4:0]   EXE_wdest,
    output logic [118:0] EXE_MEM_bus,
    output logic [31:0]  EXE_pc
);

    localparam int CW = $clog2(MUL_CYCLES);
    localparam logic [CW-1:0] LAST_ITER = CW'(MUL_CYCLES - 1);

    typedef struct packed {
        logic        multiply;
        logic        mthi;
        logic        mtlo;
        logic [11:0] alu_control;
        logic [31:0] op1;
        logic [31:0] op2;
        logic        check_ov;
        logic [3:0]  mem_control;
        logic [31:0] store_data;
        logic        mfhi;
        logic        mflo;
        logic        mtc0;
        logic        mfc0;
        logic [7:0]  cp0r_addr;
        logic        syscall;
        logic        eret;
        logic        rf_wen;
        logic [4:0]  rf_wdest;
        logic        rs_wait;
        logic        rt_wait;
        logic        inst_r;
        logic [31:0] pc;
    } id_bus_t;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} mul_state_t;

    id_bus_t     bus_r;
    mul_state_t  state;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [CW-1:0] count;
    logic [63:0] mcand;
    logic [31:0] mplier;
    logic [63:0] acc;
    logic        prod_neg;

    logic        load;
    logic        handoff;
    logic        in_multiply;
    logic [31:0] in_op1;
    logic [31:0] in_op2;
    logic [63:0] acc_sum;

    // Raw-bus fields needed on the load edge, before the register holds them
    assign in_multiply = ID_EXE_bus[170];
    assign in_op1      = ID_EXE_bus[155:124];
    assign in_op2      = ID_EXE_bus[123:92];

    assign EXE_over     = EXE_valid & (~bus_r.multiply | (state == DONE));
    assign handoff      = EXE_over & MEM_allow_in;
    assign EXE_allow_in = ~EXE_valid | handoff;
    assign load         = ID_over & EXE_allow_in;
    assign acc_sum      = acc + (mplier[0] ? mcand : 64'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus_r     <= '0;
            EXE_valid <= 1'b0;
            hi        <= '0;
            lo        <= '0;
            state     <= IDLE;
            count     <= '0;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            prod_neg  <= 1'b0;
        end else begin
            if (load) begin
                bus_r <= ID_EXE_bus;
            end

            if (cancel) begin
                EXE_valid <= 1'b0;
            end else if (EXE_allow_in) begin
                EXE_valid <= ID_over;
            end

            if (handoff && !cancel) begin
                if (bus_r.multiply) begin
                    hi <= acc[63:32];
                    lo <= acc[31:0];
                end
                if (bus_r.mthi) hi <= bus_r.op1;
                if (bus_r.mtlo) lo <= bus_r.op1;
            end

            // A load into a DONE stage only happens on handoff, so it also retires the old MULT
            if (cancel) begin
                state <= IDLE;
            end else if (load) begin
                if (in_multiply) begin
                    state    <= BUSY;
                    count    <= '0;
                    acc      <= '0;
                    mcand    <= {32'd0, in_op1[31] ? -in_op1 : in_op1};
                    mplier   <= in_op2[31] ? -in_op2 : in_op2;
                    prod_neg <= in_op1[31] ^ in_op2[31];
                end else begin
                    state <= IDLE;
                end
            end else begin
                case (state)
                    BUSY: begin
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        count  <= count + 1'b1;
                        if (count == LAST_ITER) begin
                            acc   <= prod_neg ? -acc_sum : acc_sum;
                            state <= DONE;
                        end else begin
                            acc <= acc_sum;
                        end
                    end
                    DONE: begin
                        if (handoff) state <= IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end

    logic        op_add, op_sub, op_slt, op_sltu, op_and, op_nor;
    logic        op_or, op_xor, op_sll, op_srl, op_sra, op_lui;
    logic [31:0] sum;
    logic [31:0] diff;
    logic [31:0] alu_result;
    logic [31:0] exe_result;
    logic        add_ov;
    logic        sub_ov;
    logic        ov;
    logic        rf_wen_eff;
    logic [4:0]  shamt;

    assign {op_add, op_sub, op_slt, op_sltu, op_and, op_nor,
            op_or, op_xor, op_sll, op_srl, op_sra, op_lui} = bus_r.alu_control;

    assign sum   = bus_r.op1 + bus_r.op2;
    assign diff  = bus_r.op1 - bus_r.op2;
    assign shamt = bus_r.op1[4:0];

    assign add_ov = (bus_r.op1[31] == bus_r.op2[31]) & (sum[31] != bus_r.op1[31]);
    assign sub_ov = (bus_r.op1[31] != bus_r.op2[31]) & (diff[31] != bus_r.op1[31]);
    assign ov     = bus_r.check_ov & ((op_add & add_ov) | (op_sub & sub_ov));

    // One-hot select: an all-zero control word yields zero
    assign alu_result =
          ({32{op_add}}  & sum)
        | ({32{op_sub}}  & diff)
        | ({32{op_slt}}  & {31'd0, $signed(bus_r.op1) < $signed(bus_r.op2)})
        | ({32{op_sltu}} & {31'd0, bus_r.op1 < bus_r.op2})
        | ({32{op_and}}  & (bus_r.op1 & bus_r.op2))
        | ({32{op_nor}}  & ~(bus_r.op1 | bus_r.op2))
        | ({32{op_or}}   & (bus_r.op1 | bus_r.op2))
        | ({32{op_xor}}  & (bus_r.op1 ^ bus_r.op2))
        | ({32{op_sll}}  & (bus_r.op2 << shamt))
        | ({32{op_srl}}  & (bus_r.op2 >> shamt))
        | ({32{op_sra}}  & 32'($signed(bus_r.op2) >>> shamt))
        | ({32{op_lui}}  & {bus_r.op2[15:0], 16'h0000});

    assign exe_result = bus_r.mfhi ? hi :
                        bus_r.mflo ? lo : alu_result;

    assign rf_wen_eff = bus_r.rf_wen & ~ov;
    assign EXE_wdest  = (EXE_valid & rf_wen_eff) ? bus_r.rf_wdest : 5'd0;
    assign EXE_pc     = bus_r.pc;

    assign EXE_MEM_bus = {bus_r.mem_control, bus_r.store_data, exe_result,
                          bus_r.mtc0, bus_r.mfc0, bus_r.cp0r_addr, bus_r.syscall, bus_r.eret,
                          rf_wen_eff, bus_r.rf_wdest, ov,
                          bus_r.pc};

    logic unused_bits;
    assign unused_bits = ^{bus_r.rs_wait, bus_r.rt_wait, bus_r.inst_r};

endmodule
